rotate_arbiter_rr: RTL and testbench
====================================

Name: rotate_arbiter_rr

Overview:
- Shares one 32-bit left/right rotate datapath among NUM_REQ requesters.
- Arbitration is round-robin with a valid/ready handshake per requester.
- Each accepted request is rotated and registered. The result is presented on a single response port tagged with the requester ID, with backpressure.
- Sits between the execution clients and the shared rotator, so the rotator is never instantiated per client.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_dir  input  NUM_REQ  per-requester direction: 0 = left rotate, 1 = right rotate.
- req_data  input  32*NUM_REQ  per-requester operand; requester i occupies bits [32i+31:32i].
- req_amt  input  5*NUM_REQ  per-requester rotate amount; requester i occupies bits [5i+4:5i].
- resp_valid  output  1  result register holds a valid result.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  32  rotated result.
- resp_id  output  ID_W  index of the requester that produced resp_data.
- busy  output  1  high while resp_valid is high or any req_valid is high.
- done_count  output  CNT_W  count of completed response handshakes; wraps.

Behaviour:
- Reset (async, rst=1): resp_valid=0, resp_data=0, resp_id=0, done_count=0, rr pointer=0, req_ready=0. Outputs stay at these values while rst is held.
- Slot free (combinational): free = !resp_valid | resp_ready.
- Grant (combinational):
  - When free, select the first i with req_valid[i]=1, searching from the rr pointer upward modulo NUM_REQ.
  - req_ready[i]=1 for that i only. All req_ready=0 when not free or when no request is present.
  - req_ready never depends on resp_data.
- Accept: a handshake occurs on requester i when req_valid[i] & req_ready[i] at a clock edge. On that edge:
  - resp_data <= rot(req_data_i, req_amt_i, req_dir_i).
  - resp_id <= i.
  - resp_valid <= 1.
  - rr pointer <= (i+1) mod NUM_REQ.
- Latency: one cycle. The result is visible the cycle after acceptance.
- Drain: on resp_valid & resp_ready with no new accept on the same edge, resp_valid <= 0 and resp_data/resp_id hold their last values.
- Simultaneous drain and accept on one edge: the new result replaces the old one and resp_valid stays 1. Full throughput is one op per cycle.
- Response hold: while resp_valid=1 & resp_ready=0, resp_data and resp_id are stable and no requester is granted.
- State machine, two states:
  - EMPTY (resp_valid=0): go to FULL on any accept.
  - FULL (resp_valid=1): stay FULL on stall, or on drain with simultaneous accept. Go to EMPTY on drain without accept.
- rot() arithmetic, amount n in 0..31:
  - Left rotate: out[k] = in[(k-n) mod 32].
  - Right rotate: out[k] = in[(k+n) mod 32].
  - n=0 returns the operand unchanged in both directions. The implementation must not rely on a 32-bit shift of a 32-bit value.
- done_count: increments by 1 on every resp_valid & resp_ready edge and wraps from 2^CNT_W-1 to 0.
- Requester rules:
  - A requester must hold req_valid and its operands stable until accepted.
  - Dropping req_valid before acceptance is permitted; the request is simply not served.
- Fairness: any continuously asserted requester is granted within NUM_REQ grants.
- rr pointer advances only on accept, not on idle cycles.
- Reset mid-operation:
  - Any in-flight result is discarded and no response handshake is reported.
  - The pending accept on the reset edge is lost.
  - Arbitration restarts at requester 0.

Test Plan:
- Reset, then req0 sends data=0x80000001, amt=1, dir=0 with resp_ready=1. Expect req_ready[0]=1 in the same cycle, then resp_valid=1, resp_data=0x00000003, resp_id=0 one cycle later; done_count becomes 1 after the following edge.
- req1 sends data=0x12345678, amt=0, dir=1 → resp_data=0x12345678. Then amt=4, dir=1 → 0x81234567. Then amt=31, dir=0 → 0x091A2B3C.
- All four requesters hold req_valid=1 with resp_ready=1. Expect grants in order 0,1,2,3,0,… with one grant per cycle; resp_id follows the same sequence and resp_valid stays 1 continuously.
- Result pending with resp_ready=0 for 5 cycles while req2 is valid. Expect all req_ready=0 and resp_data/resp_id stable. On the cycle resp_ready=1, expect req2 granted in the same cycle and its result following immediately (no bubble).
- Assert rst for one cycle while resp_valid=1 and req3 is valid, asynchronously mid-cycle. Expect resp_valid=0, done_count=0, and req_ready=0 immediately. After release with req2 and req3 both valid, expect req2 granted first (pointer back at 0).
- Preload done_count near wrap by running 65535 handshakes with CNT_W=16. Expect the next handshake to take done_count from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/rotate_arbiter_rr_if.sv
// Request/response bundle for the shared rotate arbiter.
// The arbiter takes the slave side and the requesters/consumer take the master side.
interface rotate_arbiter_rr_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_dir;
  logic [NUM_REQ-1:0][31:0] req_data;
  logic [NUM_REQ-1:0][4:0]  req_amt;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [31:0]              resp_data;
  logic [ID_W-1:0]          resp_id;
  logic                     busy;
  logic [CNT_W-1:0]         done_count;

  modport slave (
    input  req_valid, req_dir, req_data, req_amt, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, busy, done_count
  );
  modport master (
    output req_valid, req_dir, req_data, req_amt, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, busy, done_count
  );
endinterface

// File: rtl/rotate_arbiter_rr.sv
// Round-robin arbiter in front of one shared 32-bit rotator with a single
// registered, backpressured response slot tagged by requester ID.
module rotate_arbiter_rr #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input logic                clk,
  input logic                rst,
  rotate_arbiter_rr_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic [31:0]        data_q, data_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               free, drain, accept, gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic [NUM_REQ-1:0] gnt;
  logic [31:0]        op;
  logic [4:0]         amt;
  logic               dir;
  logic [63:0]        dbl;
  logic [5:0]         base;
  logic [31:0]        rot_res;

  assign free  = (state_q == EMPTY) | bus.resp_ready;
  assign drain = (state_q == FULL) & bus.resp_ready;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin : search
    int idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  // Grants are held off during reset so nothing is accepted on the reset edge.
  assign accept = free & gnt_vld & ~rst;
  assign gnt    = accept ? (NUM_REQ'(1) << gnt_id) : '0;

  // Rotation as a 32-bit window into the doubled operand: a right rotate by n
  // starts at bit n, a left rotate by n starts at bit 32-n.
  assign op      = bus.req_data[gnt_id];
  assign amt     = bus.req_amt[gnt_id];
  assign dir     = bus.req_dir[gnt_id];
  assign dbl     = {op, op};
  assign base    = dir ? {1'b0, amt} : (6'd32 - {1'b0, amt});
  assign rot_res = dbl[base +: 32];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (drain) cnt_d = cnt_q + 1'b1;
    if (accept) begin
      state_d = FULL;
      data_d  = rot_res;
      id_d    = gnt_id;
      ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.resp_valid = (state_q == FULL);
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = id_q;
  assign bus.busy       = (state_q == FULL) | (|bus.req_valid);
  assign bus.done_count = cnt_q;
endmodule

// File: tb/tb_rotate_arbiter_rr.sv
// Randomized and directed checks of rotate_arbiter_rr against a cycle-level
// reference model built from bit-index rotation and modulo pointer search.
module tb_rotate_arbiter_rr;
  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  logic clk, rst;
  rotate_arbiter_rr_if #(.NUM_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  rotate_arbiter_rr #(.NUM_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_vld;
  logic [31:0] m_data;
  int          m_id, m_ptr, m_cnt;
  int          last_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rot(input logic [31:0] x, input int n, input bit right);
    logic [31:0] r;
    for (int k = 0; k < 32; k++)
      r[k] = right ? x[(k + n) % 32] : x[(k - n + 32) % 32];
    return r;
  endfunction

  function automatic int ref_grant();
    if (m_vld && !bus.resp_ready) return -1;
    for (int off = 0; off < N; off++)
      if (bus.req_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt = 0; last_g = -1;
  endtask

  // Called just after a rising edge with inputs already driven; checks mid-cycle,
  // then advances the model across the next edge.
  task automatic step(input bit do_chk);
    int g;
    #4;
    g = ref_grant();
    if (do_chk) begin
      chk("req_ready",  32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("resp_valid", 32'(bus.resp_valid), 32'(m_vld));
      chk("resp_data",  bus.resp_data, m_data);
      chk("resp_id",    32'(bus.resp_id), 32'(m_id));
      chk("busy",       32'(bus.busy), 32'(m_vld || (bus.req_valid != 0)));
      chk("done_count", 32'(bus.done_count), 32'(m_cnt));
    end
    @(posedge clk);
    if (m_vld && bus.resp_ready) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (g >= 0) begin
      m_data = ref_rot(bus.req_data[g], int'(bus.req_amt[g]), bus.req_dir[g]);
      m_id   = g;
      m_vld  = 1;
      m_ptr  = (g + 1) % N;
    end else if (m_vld && bus.resp_ready) begin
      m_vld = 0;
    end
    last_g = g;
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a, input bit dr);
    bus.req_data[i] = d;
    bus.req_amt[i]  = a;
    bus.req_dir[i]  = dr;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.req_dir    = '0;
    bus.req_data   = '0;
    bus.req_amt    = '0;
    bus.resp_ready = 1'b1;
    model_reset();

    // Reset state, with requests present to show no grant while held
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '1;
    #4;
    chk("rst_ready",  32'(bus.req_ready), 32'd0);
    chk("rst_valid",  32'(bus.resp_valid), 32'd0);
    chk("rst_data",   bus.resp_data, 32'd0);
    chk("rst_id",     32'(bus.resp_id), 32'd0);
    chk("rst_count",  32'(bus.done_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = '0;

    // Left rotate by one through requester 0
    set_req(0, 32'h8000_0001, 5'd1, 1'b0);
    bus.req_valid = 4'b0001;
    step(1);
    chk("t1_data", bus.resp_data, 32'h0000_0003);
    chk("t1_id",   32'(bus.resp_id), 32'd0);
    bus.req_valid = '0;
    step(1);
    chk("t1_count", 32'(bus.done_count), 32'd1);

    // Requester 1 operand patterns
    bus.req_valid = 4'b0010;
    set_req(1, 32'h1234_5678, 5'd0, 1'b1);
    step(1);
    chk("t2_amt0", bus.resp_data, 32'h1234_5678);
    set_req(1, 32'h1234_5678, 5'd4, 1'b1);
    step(1);
    chk("t2_r4", bus.resp_data, 32'h8123_4567);
    set_req(1, 32'h1234_5678, 5'd31, 1'b0);
    step(1);
    chk("t2_l31", bus.resp_data, 32'h091A_2B3C);
    bus.req_valid = '0;
    step(1);

    // All requesters contending: round-robin, one grant per cycle
    for (int i = 0; i < N; i++) set_req(i, $urandom, 5'($urandom), 1'($urandom));
    bus.req_valid = '1;
    repeat (8) step(1);

    // Stall with requester 2 waiting, then release
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b0;
    repeat (5) step(1);
    bus.resp_ready = 1'b1;
    step(1);
    chk("t4_id", 32'(bus.resp_id), 32'd2);
    chk("t4_vld", 32'(bus.resp_valid), 32'd1);

    // Asynchronous reset mid-cycle with a result pending
    bus.req_valid  = 4'b1000;
    bus.resp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid", 32'(bus.resp_valid), 32'd0);
    chk("t5_count", 32'(bus.done_count), 32'd0);
    chk("t5_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus.req_valid  = 4'b1100;
    bus.resp_ready = 1'b1;
    step(1);
    chk("t5_first", 32'(bus.resp_id), 32'd2);

    // Random traffic: pending requests hold operands until served or dropped
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || last_g == i) begin
          bus.req_valid[i] = ($urandom_range(0, 1) == 1);
          set_req(i, $urandom, 5'($urandom), 1'($urandom));
        end else if ($urandom_range(0, 19) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // Run the completion counter up to its wrap point
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    guard = 0;
    while (m_cnt != (1 << CNT_W) - 1 && guard < 70000) begin
      step(0);
      guard++;
    end
    step(1);
    chk("wrap", 32'(bus.done_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
